warp_ibuf: RTL and testbench

//  Instruction fetch buffer and aligner directly upstream of the decoders (warp_udecode/warp_cdecode).

---
 rtl/warp_ibuf_if.sv | 33 +++
 rtl/warp_ibuf.sv | 98 +++++++++
 tb/tb_warp_ibuf.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/warp_ibuf_if.sv
// Fetch-side and decode-side signals of the warp_ibuf instruction buffer.
// The slave modport is the buffer's view; the master modport is fetch plus decode.
interface warp_ibuf_if #(
  parameter int unsigned XLEN = 64
);
  logic            i_fetch_valid;
  logic            o_fetch_ready;
  logic [63:0]     i_fetch_data;
  logic [1:0]      i_fetch_first;
  logic            i_flush;
  logic [XLEN-1:0] i_flush_pc;
  logic            o_inst0_valid;
  logic [31:0]     o_inst0;
  logic            o_inst0_c;
  logic [XLEN-1:0] o_inst0_pc;
  logic            o_inst1_valid;
  logic [31:0]     o_inst1;
  logic            o_inst1_c;
  logic [XLEN-1:0] o_inst1_pc;
  logic            i_dec_ready;

  modport master (
    output i_fetch_valid, i_fetch_data, i_fetch_first, i_flush, i_flush_pc, i_dec_ready,
    input  o_fetch_ready, o_inst0_valid, o_inst0, o_inst0_c, o_inst0_pc,
    input  o_inst1_valid, o_inst1, o_inst1_c, o_inst1_pc
  );

  modport slave (
    input  i_fetch_valid, i_fetch_data, i_fetch_first, i_flush, i_flush_pc, i_dec_ready,
    output o_fetch_ready, o_inst0_valid, o_inst0, o_inst0_c, o_inst0_pc,
    output o_inst1_valid, o_inst1, o_inst1_c, o_inst1_pc
  );
endinterface

// File: rtl/warp_ibuf.sv
// Instruction fetch buffer: halfword FIFO fed by 64-bit fetch blocks, presenting
// up to two aligned 16/32-bit instructions per cycle with compressed flag and PC.
module warp_ibuf #(
  parameter int unsigned     DEPTH    = 16,
  parameter int unsigned     XLEN     = 64,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(64'h8000_0000)
) (
  input logic        i_clk,
  input logic        i_rst,
  warp_ibuf_if.slave bus
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [15:0]     mem [DEPTH];
  logic [PW-1:0]   head;
  logic [PW-1:0]   tail;
  logic [CW-1:0]   count;
  logic [XLEN-1:0] head_pc;

  logic [15:0]   hw0_lo, hw0_hi, hw1_lo, hw1_hi;
  logic          c0, c1, v0, v1;
  logic [1:0]    len0, len1;
  logic [PW-1:0] idx1;
  logic [2:0]    push_n, pop_n;
  logic          fetch_ready, push_en, pop_en;
  logic [PW-1:0] wr_idx [4];
  logic [3:0]    wr_en;

  // Slot decode straight from the registered head/count
  always_comb begin
    hw0_lo = mem[head];
    hw0_hi = mem[head + PW'(1)];
    c0     = hw0_lo[1:0] != 2'b11;
    len0   = c0 ? 2'd1 : 2'd2;
    v0     = count >= CW'(len0);
    idx1   = head + PW'(len0);
    hw1_lo = mem[idx1];
    hw1_hi = mem[idx1 + PW'(1)];
    c1     = hw1_lo[1:0] != 2'b11;
    len1   = c1 ? 2'd1 : 2'd2;
    v1     = v0 && (count >= CW'(3'(len0) + 3'(len1)));
    pop_n  = (v0 ? 3'(len0) : 3'd0) + (v1 ? 3'(len1) : 3'd0);
  end

  assign fetch_ready = count <= CW'(DEPTH - 4);
  assign push_n      = 3'd4 - 3'(bus.i_fetch_first);
  assign push_en     = bus.i_fetch_valid && fetch_ready && !bus.i_flush;
  assign pop_en      = bus.i_dec_ready && !bus.i_flush;

  // Halfwords below i_fetch_first are skipped; the rest pack densely from tail
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      wr_en[k]  = push_en && (2'(k) >= bus.i_fetch_first);
      wr_idx[k] = tail + PW'(k) - PW'(bus.i_fetch_first);
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      if (wr_en[0]) mem[wr_idx[0]] <= bus.i_fetch_data[15:0];
      if (wr_en[1]) mem[wr_idx[1]] <= bus.i_fetch_data[31:16];
      if (wr_en[2]) mem[wr_idx[2]] <= bus.i_fetch_data[47:32];
      if (wr_en[3]) mem[wr_idx[3]] <= bus.i_fetch_data[63:48];
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      head    <= '0;
      tail    <= '0;
      count   <= '0;
      head_pc <= RESET_PC;
    end else if (bus.i_flush) begin
      head    <= '0;
      tail    <= '0;
      count   <= '0;
      head_pc <= bus.i_flush_pc & ~XLEN'(1);
    end else begin
      if (push_en) tail <= tail + PW'(push_n);
      if (pop_en) begin
        head    <= head + PW'(pop_n);
        head_pc <= head_pc + XLEN'({pop_n, 1'b0});
      end
      count <= count + (push_en ? CW'(push_n) : CW'(0)) - (pop_en ? CW'(pop_n) : CW'(0));
    end
  end

  assign bus.o_fetch_ready = fetch_ready;
  assign bus.o_inst0_valid = v0;
  assign bus.o_inst0       = c0 ? {16'b0, hw0_lo} : {hw0_hi, hw0_lo};
  assign bus.o_inst0_c     = c0;
  assign bus.o_inst0_pc    = head_pc;
  assign bus.o_inst1_valid = v1;
  assign bus.o_inst1       = c1 ? {16'b0, hw1_lo} : {hw1_hi, hw1_lo};
  assign bus.o_inst1_c     = c1;
  assign bus.o_inst1_pc    = head_pc + XLEN'({len0, 1'b0});
endmodule

// File: tb/tb_warp_ibuf.sv
// Bench for warp_ibuf: cycle table for directed cases, hand sequences for reset
// and PC wrap, and a scoreboard against a generated instruction stream.
module tb_warp_ibuf;
  localparam int unsigned XLEN = 64;
  localparam logic [63:0] NOP4  = 64'h0001_0001_0001_0001;
  localparam logic [63:0] ADDI2 = 64'h0010_0093_0010_0093;
  localparam logic [63:0] P     = 64'h8000_0000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  warp_ibuf_if #(.XLEN(XLEN)) bus();

  warp_ibuf #(.DEPTH(16), .XLEN(XLEN), .RESET_PC(64'h8000_0000)) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus  (bus.slave)
  );

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic        fv;
    logic [63:0] data;
    logic [1:0]  first;
    logic        flush;
    logic [63:0] fpc;
    logic        dr;
    logic        erdy;
    logic        ev0;
    logic [31:0] ei0;
    logic        ec0;
    logic [63:0] ep0;
    logic        ev1;
    logic [31:0] ei1;
    logic        ec1;
    logic [63:0] ep1;
  } vec_t;

  typedef struct {
    logic [31:0] inst;
    logic        c;
    logic [63:0] pc;
  } exp_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.i_fetch_valid = 1'b0;
    bus.i_fetch_data  = '0;
    bus.i_fetch_first = 2'd0;
    bus.i_flush       = 1'b0;
    bus.i_flush_pc    = '0;
    bus.i_dec_ready   = 1'b0;
  endtask

  function automatic vec_t v(input logic fv, input logic [63:0] d, input logic [1:0] f,
                             input logic fl, input logic [63:0] fpc, input logic dr, input logic rdy,
                             input logic ev0, input logic [31:0] i0, input logic c0, input logic [63:0] p0,
                             input logic ev1, input logic [31:0] i1, input logic c1, input logic [63:0] p1);
    vec_t r;
    r.fv = fv; r.data = d; r.first = f; r.flush = fl; r.fpc = fpc; r.dr = dr; r.erdy = rdy;
    r.ev0 = ev0; r.ei0 = i0; r.ec0 = c0; r.ep0 = p0;
    r.ev1 = ev1; r.ei1 = i1; r.ec1 = c1; r.ep1 = p1;
    return r;
  endfunction

  // Compare one slot against the scoreboard head
  task automatic consume(input string tag, input logic [31:0] inst, input logic c,
                         input logic [63:0] pc, inout exp_t sb[$]);
    exp_t e;
    if (sb.size() == 0) begin
      check({tag, ".extra"}, 64'd1, 64'd0);
    end else begin
      e = sb.pop_front();
      check({tag, ".inst"}, 64'(inst), 64'(e.inst));
      check({tag, ".c"}, 64'(c), 64'(e.c));
      check({tag, ".pc"}, pc, e.pc);
    end
  endtask

  initial begin
    vec_t        tbl[$];
    exp_t        sb[$];
    logic [15:0] hwq[$];
    logic [15:0] h, hi;
    logic [63:0] pc, spc;
    logic [1:0]  first;
    logic        rdy, fv;
    int          nblk, bi, cyc;

    idle();
    step();
    step();
    rst = 1'b0;

    // Compressed pairs, 32-bit pairs, straddling 32-bit, fill/backpressure, flush
    tbl.push_back(v(1, NOP4, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, 0, 0, 0, 0, 1, 1, 1, 32'h1, 1, P + 0, 1, 32'h1, 1, P + 2));
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 1, 1, 32'h1, 1, P + 4, 1, 32'h1, 1, P + 6));
    tbl.push_back(v(0, 0, 0, 0, 0, 1, 1, 1, 32'h1, 1, P + 4, 1, 32'h1, 1, P + 6));
    tbl.push_back(v(1, ADDI2, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, 0, 0, 0, 0, 1, 1, 1, 32'h00100093, 0, P + 8, 1, 32'h00100093, 0, P + 'hC));
    tbl.push_back(v(1, 64'h0093_0001_0001_0001, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, 0, 0, 0, 0, 1, 1, 1, 32'h1, 1, P + 'h10, 1, 32'h1, 1, P + 'h12));
    tbl.push_back(v(0, 0, 0, 0, 0, 1, 1, 1, 32'h1, 1, P + 'h14, 0, 0, 0, 0));
    tbl.push_back(v(0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(1, 64'h0001_0001_0001_0010, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, 0, 0, 0, 0, 1, 1, 1, 32'h00100093, 0, P + 'h16, 1, 32'h1, 1, P + 'h1A));
    tbl.push_back(v(0, 0, 0, 0, 0, 1, 1, 1, 32'h1, 1, P + 'h1C, 1, 32'h1, 1, P + 'h1E));
    tbl.push_back(v(1, NOP4, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(1, NOP4, 0, 0, 0, 0, 1, 1, 32'h1, 1, P + 'h20, 1, 32'h1, 1, P + 'h22));
    tbl.push_back(v(1, NOP4, 0, 0, 0, 0, 1, 1, 32'h1, 1, P + 'h20, 1, 32'h1, 1, P + 'h22));
    tbl.push_back(v(1, NOP4, 0, 0, 0, 0, 1, 1, 32'h1, 1, P + 'h20, 1, 32'h1, 1, P + 'h22));
    tbl.push_back(v(1, NOP4, 0, 0, 0, 0, 0, 1, 32'h1, 1, P + 'h20, 1, 32'h1, 1, P + 'h22));
    tbl.push_back(v(0, 0, 0, 0, 0, 1, 0, 1, 32'h1, 1, P + 'h20, 1, 32'h1, 1, P + 'h22));
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 1, 32'h1, 1, P + 'h24, 1, 32'h1, 1, P + 'h26));
    tbl.push_back(v(0, 0, 0, 0, 0, 1, 0, 1, 32'h1, 1, P + 'h24, 1, 32'h1, 1, P + 'h26));
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 1, 1, 32'h1, 1, P + 'h28, 1, 32'h1, 1, P + 'h2A));
    tbl.push_back(v(1, NOP4, 0, 1, 64'h8000_1007, 1, 1, 1, 32'h1, 1, P + 'h28, 1, 32'h1, 1, P + 'h2A));
    tbl.push_back(v(1, 64'h4501_0009_0005_0001, 3, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 1, 1, 32'h4501, 1, 64'h8000_1006, 0, 0, 0, 0));
    tbl.push_back(v(0, 0, 0, 0, 0, 1, 1, 1, 32'h4501, 1, 64'h8000_1006, 0, 0, 0, 0));
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));

    foreach (tbl[i]) begin
      bus.i_fetch_valid = tbl[i].fv;
      bus.i_fetch_data  = tbl[i].data;
      bus.i_fetch_first = tbl[i].first;
      bus.i_flush       = tbl[i].flush;
      bus.i_flush_pc    = tbl[i].fpc;
      bus.i_dec_ready   = tbl[i].dr;
      check($sformatf("row%0d.ready", i), 64'(bus.o_fetch_ready), 64'(tbl[i].erdy));
      check($sformatf("row%0d.v0", i), 64'(bus.o_inst0_valid), 64'(tbl[i].ev0));
      check($sformatf("row%0d.v1", i), 64'(bus.o_inst1_valid), 64'(tbl[i].ev1));
      if (tbl[i].ev0) begin
        check($sformatf("row%0d.inst0", i), 64'(bus.o_inst0), 64'(tbl[i].ei0));
        check($sformatf("row%0d.c0", i), 64'(bus.o_inst0_c), 64'(tbl[i].ec0));
        check($sformatf("row%0d.pc0", i), bus.o_inst0_pc, tbl[i].ep0);
      end
      if (tbl[i].ev1) begin
        check($sformatf("row%0d.inst1", i), 64'(bus.o_inst1), 64'(tbl[i].ei1));
        check($sformatf("row%0d.c1", i), 64'(bus.o_inst1_c), 64'(tbl[i].ec1));
        check($sformatf("row%0d.pc1", i), bus.o_inst1_pc, tbl[i].ep1);
      end
      step();
    end

    // Reset mid-operation beats a concurrent flush, push and pop
    idle();
    bus.i_fetch_valid = 1'b1;
    bus.i_fetch_data  = ADDI2;
    step();
    rst = 1'b1;
    bus.i_flush = 1'b1;
    bus.i_flush_pc = 64'h1234;
    bus.i_dec_ready = 1'b1;
    step();
    rst = 1'b0;
    idle();
    check("rst.v0", 64'(bus.o_inst0_valid), 64'd0);
    check("rst.ready", 64'(bus.o_fetch_ready), 64'd1);
    bus.i_fetch_valid = 1'b1;
    bus.i_fetch_data  = NOP4;
    step();
    idle();
    check("rst.v1", 64'(bus.o_inst1_valid), 64'd1);
    check("rst.pc0", bus.o_inst0_pc, P);

    // PC wraps modulo 2^XLEN
    bus.i_flush = 1'b1;
    bus.i_flush_pc = 64'hFFFF_FFFF_FFFF_FFFC;
    step();
    idle();
    bus.i_fetch_valid = 1'b1;
    bus.i_fetch_data  = NOP4;
    bus.i_fetch_first = 2'd2;
    step();
    idle();
    check("wrap.pc0", bus.o_inst0_pc, 64'hFFFF_FFFF_FFFF_FFFC);
    check("wrap.pc1", bus.o_inst1_pc, 64'hFFFF_FFFF_FFFF_FFFE);
    bus.i_dec_ready = 1'b1;
    bus.i_fetch_valid = 1'b1;
    bus.i_fetch_data  = NOP4;
    step();
    idle();
    check("wrap.pc_next", bus.o_inst0_pc, 64'h0);

    // Random mixed streams against the scoreboard
    for (int s = 0; s < 100; s++) begin
      spc = P + 64'($urandom_range(0, 4095) << 1);
      idle();
      bus.i_flush = 1'b1;
      bus.i_flush_pc = spc;
      step();
      idle();
      first = spc[2:1];
      pc = spc;
      hwq.delete();
      sb.delete();
      for (int j = 0; j < int'(first); j++) hwq.push_back(16'($urandom));
      for (int n = $urandom_range(4, 24); n > 0; n--) begin
        if ($urandom_range(0, 1) == 0) begin
          h = 16'($urandom);
          h[1:0] = 2'($urandom_range(0, 2));
          hwq.push_back(h);
          sb.push_back('{inst: {16'h0, h}, c: 1'b1, pc: pc});
          pc += 2;
        end else begin
          h = 16'($urandom) | 16'h0003;
          hi = 16'($urandom);
          hwq.push_back(h);
          hwq.push_back(hi);
          sb.push_back('{inst: {hi, h}, c: 1'b0, pc: pc});
          pc += 4;
        end
      end
      while (hwq.size() % 4 != 0) begin
        hwq.push_back(16'h0001);
        sb.push_back('{inst: 32'h1, c: 1'b1, pc: pc});
        pc += 2;
      end
      nblk = hwq.size() / 4;
      bi = 0;
      cyc = 0;
      while ((bi < nblk || sb.size() != 0) && cyc < 400) begin
        fv = (bi < nblk) && ($urandom_range(0, 3) != 0);
        bus.i_fetch_valid = fv;
        bus.i_fetch_first = (bi == 0) ? first : 2'd0;
        bus.i_fetch_data  = (bi < nblk) ? {hwq[4*bi+3], hwq[4*bi+2], hwq[4*bi+1], hwq[4*bi]} : 64'h0;
        bus.i_dec_ready   = $urandom_range(0, 3) != 0;
        rdy = bus.o_fetch_ready;
        if (bus.o_inst1_valid && !bus.o_inst0_valid)
          check($sformatf("rnd%0d.v1_implies_v0", s), 64'd1, 64'd0);
        if (bus.i_dec_ready && bus.o_inst0_valid)
          consume($sformatf("rnd%0d.s0", s), bus.o_inst0, bus.o_inst0_c, bus.o_inst0_pc, sb);
        if (bus.i_dec_ready && bus.o_inst1_valid)
          consume($sformatf("rnd%0d.s1", s), bus.o_inst1, bus.o_inst1_c, bus.o_inst1_pc, sb);
        step();
        if (fv && rdy) bi++;
        cyc++;
      end
      idle();
      if (cyc >= 400) check($sformatf("rnd%0d.timeout", s), 64'(sb.size()), 64'd0);
      check($sformatf("rnd%0d.drained", s), 64'(bus.o_inst0_valid), 64'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
